// File: rtl/risc_program_loader_pkg.sv
// Shared definitions for the RISC program loader: host command bytes, error codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package risc_program_loader_pkg;

    // Host command bytes. A write frame is CMD, ADDR, DHI, DLO.
    localparam logic [7:0] CMD_WR_IR = 8'h01;
    localparam logic [7:0] CMD_WR_DM = 8'h02;
    localparam logic [7:0] CMD_RUN   = 8'h03;
    localparam logic [7:0] CMD_ABORT = 8'h04;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_CMD  = 2'd1,
        ERR_IR_RANGE = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_WRITE,
        ST_RELEASE,
        ST_RUNNING
    } state_e;

    function automatic logic is_write_cmd(input logic [7:0] b);
        return (b == CMD_WR_IR) || (b == CMD_WR_DM);
    endfunction

endpackage

// File: rtl/risc_program_loader_if.sv
// Host byte stream into the loader: valid/ready, one byte per transfer.
// Latency: n/a (wires only).
// Backpressure: transfer happens only on in_valid & in_ready; the host holds data while in_ready is low.
// Ports: in_valid/in_data driven by the host (master), in_ready driven by the loader (slave).
interface risc_program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/risc_program_loader_run_timer.sv
// Run timer: saturating cycle counter with a clear, an enable and a timeout compare.
// Latency: count updates one edge after enable/clear; timeout is combinational on the count.
// Backpressure: none.
// Ports: clk, reset (async, high), clear, enable, count[CNT_W], timeout.
module loader_run_timer #(
    parameter int CNT_W      = 24,
    parameter int MAX_CYCLES = 2**20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout = (count == LIMIT);

endmodule

// File: rtl/risc_program_loader.sv
// Host-side loader: parses host bytes into IR/DM write frames, releases the core, times the run, captures outR.
// Latency: write strobe one cycle after the DLO byte; release one cycle after RUN; result one edge after cpu_done.
// Backpressure: in_ready low in WRITE and RELEASE; bytes are held by the host, never dropped.
// Ports: clk, reset, host (byte stream), test_normal, cpu_reset_n, ext_IR_we, ext_DM_we, ext_addr, ext_data,
//        cpu_done, cpu_outR, running, result, result_valid, cycle_count, err_code.
module risc_program_loader
    import risc_program_loader_pkg::*;
#(
    parameter int IR_DEPTH   = 32,
    parameter int CNT_W      = 24,
    parameter int MAX_CYCLES = 2**20
) (
    input  logic                        clk,
    input  logic                        reset,
    risc_program_loader_if.slave        host,
    output logic                        test_normal,
    output logic                        cpu_reset_n,
    output logic                        ext_IR_we,
    output logic                        ext_DM_we,
    output logic [7:0]                  ext_addr,
    output logic [15:0]                 ext_data,
    input  logic                        cpu_done,
    input  logic [15:0]                 cpu_outR,
    output logic                        running,
    output logic [15:0]                 result,
    output logic                        result_valid,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [1:0]                  err_code
);

    localparam logic [8:0] IR_LIMIT = 9'(IR_DEPTH);

    state_e state_q, state_d;
    err_e   err_q;
    logic   tgt_ir_q;      // current frame targets instruction memory
    logic   drop_q;        // current frame is rejected; suppress its strobe
    logic   xfer;
    logic   abort_req;
    logic   leave_run;
    logic   timer_clear, timer_en, timeout;

    assign host.in_ready = (state_q != ST_WRITE) && (state_q != ST_RELEASE);
    assign xfer          = host.in_valid && host.in_ready;
    assign abort_req     = xfer && (host.in_data == CMD_ABORT);
    assign leave_run     = (state_q == ST_RUNNING) && (state_d == ST_IDLE);
    assign err_code      = err_q;

    loader_run_timer #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .count   (cycle_count),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Within RUNNING, done beats abort beats timeout. The timeout cycle does not
    // count, so cycle_count reads MAX_CYCLES-1 after a timeout.
    always_comb begin
        state_d     = state_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (is_write_cmd(host.in_data))     state_d = ST_ADDR;
                    else if (host.in_data == CMD_RUN)   state_d = ST_RELEASE;
                end
            end
            ST_ADDR:  if (xfer) state_d = ST_DHI;
            ST_DHI:   if (xfer) state_d = ST_DLO;
            ST_DLO:   if (xfer) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_RELEASE: begin
                timer_clear = 1'b1;
                state_d     = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (cpu_done || abort_req) begin
                    timer_en = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timeout) begin
                    state_d  = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            test_normal  <= 1'b1;
            cpu_reset_n  <= 1'b0;
            ext_IR_we    <= 1'b0;
            ext_DM_we    <= 1'b0;
            ext_addr     <= '0;
            ext_data     <= '0;
            running      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err_q        <= ERR_NONE;
            tgt_ir_q     <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            ext_IR_we    <= 1'b0;
            ext_DM_we    <= 1'b0;
            result_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        err_q <= ERR_NONE;
                        if (is_write_cmd(host.in_data)) begin
                            tgt_ir_q <= (host.in_data == CMD_WR_IR);
                            drop_q   <= 1'b0;
                        end else if ((host.in_data != CMD_RUN) && (host.in_data != CMD_ABORT)) begin
                            err_q <= ERR_BAD_CMD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (xfer) begin
                        ext_addr <= host.in_data;
                        if (tgt_ir_q && ({1'b0, host.in_data} >= IR_LIMIT)) begin
                            err_q  <= ERR_IR_RANGE;
                            drop_q <= 1'b1;
                        end
                    end
                end
                ST_DHI: if (xfer) ext_data[15:8] <= host.in_data;
                ST_DLO: begin
                    // Strobe is registered here so it lines up with the WRITE cycle,
                    // by which time addr and data are already stable.
                    if (xfer) begin
                        ext_data[7:0] <= host.in_data;
                        ext_IR_we     <= !drop_q && tgt_ir_q;
                        ext_DM_we     <= !drop_q && !tgt_ir_q;
                    end
                end
                ST_RELEASE: begin
                    test_normal <= 1'b0;
                    cpu_reset_n <= 1'b1;
                    running     <= 1'b1;
                end
                ST_RUNNING: begin
                    if (cpu_done) begin
                        result       <= cpu_outR;
                        result_valid <= 1'b1;
                    end else if (abort_req) begin
                        err_q <= ERR_NONE;
                    end else if (timeout) begin
                        err_q <= ERR_TIMEOUT;
                    end else if (xfer) begin
                        err_q <= ERR_BAD_CMD;
                    end
                end
                default: ;
            endcase
            if (leave_run) begin
                test_normal <= 1'b1;
                cpu_reset_n <= 1'b0;
                running     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_risc_program_loader.sv
// Bench for risc_program_loader: directed host byte vectors, a tiny behavioural core, and a scoreboard.
// Latency: n/a.
// Backpressure: host driver waits on in_ready with a bounded cycle budget.
module tb_risc_program_loader;

    localparam int IR_DEPTH   = 32;
    localparam int CNT_W      = 24;
    localparam int MAX_CYCLES = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    risc_program_loader_if host ();

    logic             test_normal, cpu_reset_n, ext_IR_we, ext_DM_we;
    logic [7:0]       ext_addr;
    logic [15:0]      ext_data;
    logic             cpu_done;
    logic [15:0]      cpu_outR;
    logic             running;
    logic [15:0]      result;
    logic             result_valid;
    logic [CNT_W-1:0] cycle_count;
    logic [1:0]       err_code;

    risc_program_loader #(.IR_DEPTH(IR_DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (host),
        .test_normal  (test_normal),
        .cpu_reset_n  (cpu_reset_n),
        .ext_IR_we    (ext_IR_we),
        .ext_DM_we    (ext_DM_we),
        .ext_addr     (ext_addr),
        .ext_data     (ext_data),
        .cpu_done     (cpu_done),
        .cpu_outR     (cpu_outR),
        .running      (running),
        .result       (result),
        .result_valid (result_valid),
        .cycle_count  (cycle_count),
        .err_code     (err_code)
    );

    // Tiny core: one instruction per cycle. 1xxx = load outR, 2xxx = jump, Fxxx = halt, else nop.
    logic [15:0] ir_mem [0:31];
    logic [4:0]  pc;
    logic [15:0] out_r;
    initial for (int i = 0; i < 32; i++) ir_mem[i] = 16'h0000;
    assign cpu_done = cpu_reset_n && !test_normal && (ir_mem[pc][15:12] == 4'hF);
    assign cpu_outR = out_r;
    always @(posedge clk) begin
        if (ext_IR_we) ir_mem[ext_addr[4:0]] <= ext_data;
        if (!cpu_reset_n) begin
            pc    <= 5'd0;
            out_r <= 16'h0000;
        end else if (!test_normal && !cpu_done) begin
            if (ir_mem[pc][15:12] == 4'h1) out_r <= {4'h0, ir_mem[pc][11:0]};
            if (ir_mem[pc][15:12] == 4'h2) pc <= ir_mem[pc][4:0];
            else                           pc <= pc + 5'd1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected writes and results, filled from the bench's own view of the bytes sent.
    typedef struct { logic is_ir; logic [7:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] res; int cnt; } res_t;
    wr_t  wr_q [$];
    res_t res_q [$];
    logic [15:0] prog [0:31];
    initial for (int i = 0; i < 32; i++) prog[i] = 16'h0000;

    // Predict a run from the program image: value of the last load before halt and cycles to halt.
    function automatic res_t predict_run();
        res_t r;
        int p;
        r.res = 16'h0000;
        r.cnt = 0;
        p = 0;
        for (int k = 0; k < 1000; k++) begin
            r.cnt = r.cnt + 1;
            if (prog[p][15:12] == 4'hF) return r;
            if (prog[p][15:12] == 4'h1) r.res = {4'h0, prog[p][11:0]};
            if (prog[p][15:12] == 4'h2) p = int'(prog[p][4:0]);
            else p = (p + 1) % 32;
        end
        r.cnt = -1;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (ext_IR_we || ext_DM_we) begin
                check("strobe_running", 32'(running), 32'd0);
                check("strobe_test_normal", 32'(test_normal), 32'd1);
                if (wr_q.size() == 0) begin
                    check("unexpected_strobe", 32'({ext_IR_we, ext_DM_we}), 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("strobe_kind", 32'({ext_IR_we, ext_DM_we}), w.is_ir ? 32'd2 : 32'd1);
                    check("strobe_addr", 32'(ext_addr), 32'(w.addr));
                    check("strobe_data", 32'(ext_data), 32'(w.data));
                end
            end
            if (result_valid) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result_valid", 32'(result_valid), 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result_value", 32'(result), 32'(r.res));
                    check("result_cycles", 32'(cycle_count), 32'(r.cnt));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until accepted; called at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        host.in_valid = 1'b1;
        host.in_data  = b;
        @(negedge clk);
        while (!host.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!host.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, in_ready=%0b expected 1", b, host.in_ready);
        end
        tick();
        host.in_valid = 1'b0;
        host.in_data  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] hi,
                              input logic [7:0] lo);
        wr_t w;
        send_byte(cmd);
        send_byte(addr);
        send_byte(hi);
        if (!(cmd == 8'h01 && int'(addr) >= IR_DEPTH)) begin
            w.is_ir = (cmd == 8'h01);
            w.addr  = addr;
            w.data  = {hi, lo};
            wr_q.push_back(w);
            if (cmd == 8'h01) prog[addr[4:0]] = {hi, lo};
        end
        send_byte(lo);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_test_normal"}, 32'(test_normal), 32'd1);
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
        check({tag, "_we"}, 32'({ext_IR_we, ext_DM_we}), 32'd0);
        check({tag, "_addr"}, 32'(ext_addr), 32'd0);
        check({tag, "_data"}, 32'(ext_data), 32'd0);
        check({tag, "_running"}, 32'(running), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        check({tag, "_err"}, 32'(err_code), 32'd0);
        check({tag, "_in_ready"}, 32'(host.in_ready), 32'd1);
    endtask

    initial begin
        res_t exp_r;
        int   n;
        host.in_valid = 1'b0;
        host.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        // 1: IR write frame, then a byte held through WRITE must wait.
        send_frame(8'h01, 8'h05, 8'h12, 8'h34);
        check("t1_ir_we", 32'(ext_IR_we), 32'd1);
        check("t1_addr", 32'(ext_addr), 32'h05);
        check("t1_data", 32'(ext_data), 32'h1234);
        check("t1_test_normal", 32'(test_normal), 32'd1);
        host.in_valid = 1'b1;
        host.in_data  = 8'h7E;
        @(negedge clk);
        check("t5_write_not_ready", 32'(host.in_ready), 32'd0);
        tick();
        check("t5_write_not_consumed", 32'(err_code), 32'd0);
        @(negedge clk);
        check("t5_idle_ready", 32'(host.in_ready), 32'd1);
        tick();
        host.in_valid = 1'b0;
        check("t5_bad_cmd_err", 32'(err_code), 32'd1);

        // 2: DM write, then out-of-range IR write dropped.
        send_frame(8'h02, 8'hFF, 8'hAB, 8'hCD);
        check("t2_dm_we", 32'(ext_DM_we), 32'd1);
        check("t2_addr", 32'(ext_addr), 32'hFF);
        check("t2_data", 32'(ext_data), 32'hABCD);
        check("t2_err_cleared", 32'(err_code), 32'd0);
        send_frame(8'h01, 8'h20, 8'h00, 8'h00);
        check("t2_drop_no_we", 32'({ext_IR_we, ext_DM_we}), 32'd0);
        check("t2_range_err", 32'(err_code), 32'd2);
        tick();
        check("t2_queue_drained", 32'(wr_q.size()), 32'd0);

        // 3: three-instruction program ending in halt.
        send_frame(8'h01, 8'h00, 8'h10, 8'h05);
        send_frame(8'h01, 8'h01, 8'h11, 8'h23);
        send_frame(8'h01, 8'h02, 8'hF0, 8'h00);
        exp_r = predict_run();
        check("t3_model_res", 32'(exp_r.res), 32'h0123);
        check("t3_model_cnt", 32'(exp_r.cnt), 32'd3);
        res_q.push_back(exp_r);
        send_byte(8'h03);
        check("t3_release_running", 32'(running), 32'd0);
        check("t3_release_ready", 32'(host.in_ready), 32'd0);
        tick();
        check("t3_running", 32'(running), 32'd1);
        check("t3_test_normal", 32'(test_normal), 32'd0);
        check("t3_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        check("t3_count_start", 32'(cycle_count), 32'd0);
        n = 0;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        check("t3_result_valid", 32'(result_valid), 32'd1);
        check("t3_result", 32'(result), 32'h0123);
        check("t3_cycles", 32'(cycle_count), 32'd3);
        check("t3_rehold", 32'({running, test_normal, cpu_reset_n}), 32'b010);
        tick();
        check("t3_result_pulse", 32'(result_valid), 32'd0);

        // 4: tight loop until timeout.
        send_frame(8'h01, 8'h00, 8'h20, 8'h00);
        send_byte(8'h03);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!running) break;
            n++;
        end
        check("t4_run_cycles", 32'(n), 32'(MAX_CYCLES));
        check("t4_timeout_err", 32'(err_code), 32'd3);
        check("t4_count", 32'(cycle_count), 32'd15);
        check("t4_rehold", 32'({running, test_normal, cpu_reset_n}), 32'b010);
        send_byte(8'h04);
        check("t4_err_cleared", 32'(err_code), 32'd0);

        // 5: byte held through RELEASE, discarded byte mid-run, then abort.
        send_byte(8'h03);
        host.in_valid = 1'b1;
        host.in_data  = 8'h55;
        @(negedge clk);
        check("t5_release_not_ready", 32'(host.in_ready), 32'd0);
        tick();
        check("t5_release_not_consumed", 32'(err_code), 32'd0);
        tick();
        host.in_valid = 1'b0;
        check("t5_run_discard_err", 32'(err_code), 32'd1);
        check("t5_still_running", 32'(running), 32'd1);
        repeat (3) tick();
        send_byte(8'h04);
        check("t5_abort_stopped", 32'({running, test_normal, cpu_reset_n}), 32'b010);
        repeat (3) tick();

        // 6: reset after DHI byte of a frame.
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'hAA);
        reset = 1'b1;
        #2;
        check_reset_vals("midframe");
        tick();
        reset = 1'b0;
        tick();
        send_frame(8'h01, 8'h07, 8'hBE, 8'hEF);
        check("t6_ir_we", 32'(ext_IR_we), 32'd1);
        check("t6_data", 32'(ext_data), 32'hBEEF);
        repeat (2) tick();

        check("end_writes_drained", 32'(wr_q.size()), 32'd0);
        check("end_results_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
